// File: rtl/decoder_scan_138.sv
// Registered 138-style line decoder with a direct mode and a
// scanning sequencer (programmable dwell, blanking between channels).
module decoder_scan_138 #(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter int BLANK      = 1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en1_n,
  input  logic                   en2_n,
  input  logic                   en3,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       data_in,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic [SEL_W-1:0]       last_idx,
  output logic [(1<<SEL_W)-1:0]  data_out,
  output logic [SEL_W-1:0]       cur_sel,
  output logic                   busy,
  output logic                   wrap
);

  localparam int N  = 1 << SEL_W;
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  localparam logic [N-1:0]  OFF     = ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};
  localparam logic [BW-1:0] BL_INIT = (BLANK > 0) ? BW'(BLANK - 1) : '0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DIRECT     = 2'd1,
    SCAN_ON    = 2'd2,
    SCAN_BLANK = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         data_out_q, data_out_d;
  logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
  logic                 busy_q, busy_d;
  logic                 wrap_q, wrap_d;
  logic [DWELL_W-1:0]   rem_q, rem_d;
  logic [BW-1:0]        bl_q, bl_d;

  logic                 enabled;
  logic [DWELL_W-1:0]   dwell_m1;
  logic                 adv_wrap;
  logic [SEL_W-1:0]     adv_sel;

  function automatic logic [N-1:0] lines(input logic [SEL_W-1:0] s);
    logic [N-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return ACTIVE_LOW ? ~oh : oh;
  endfunction

  // rem counts the remaining active cycles of the current channel
  always_comb begin
    enabled  = ~en1_n & ~en2_n & en3;
    dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    adv_wrap = (cur_sel_q >= last_idx);
    adv_sel  = adv_wrap ? '0 : cur_sel_q + SEL_W'(1);

    state_d    = state_q;
    data_out_d = data_out_q;
    cur_sel_d  = cur_sel_q;
    wrap_d     = 1'b0;
    rem_d      = rem_q;
    bl_d       = bl_q;

    if (!enabled) begin
      state_d    = IDLE;
      data_out_d = OFF;
      rem_d      = '0;
    end else if (!mode) begin
      state_d    = DIRECT;
      cur_sel_d  = data_in;
      data_out_d = lines(data_in);
      rem_d      = '0;
    end else begin
      unique case (state_q)
        IDLE, DIRECT: begin
          state_d = SCAN_ON;
          if (state_q == DIRECT) cur_sel_d = '0;
          data_out_d = lines(cur_sel_d);
          rem_d      = dwell_m1;
        end
        SCAN_ON: begin
          if (rem_q != '0) begin
            rem_d = rem_q - DWELL_W'(1);
          end else if (BLANK > 0) begin
            state_d    = SCAN_BLANK;
            bl_d       = BL_INIT;
            data_out_d = OFF;
          end else begin
            cur_sel_d  = adv_sel;
            wrap_d     = adv_wrap;
            data_out_d = lines(adv_sel);
            rem_d      = dwell_m1;
          end
        end
        SCAN_BLANK: begin
          if (bl_q != '0) begin
            bl_d = bl_q - BW'(1);
          end else begin
            state_d    = SCAN_ON;
            cur_sel_d  = adv_sel;
            wrap_d     = adv_wrap;
            data_out_d = lines(adv_sel);
            rem_d      = dwell_m1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == SCAN_ON) || (state_d == SCAN_BLANK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_out_q <= OFF;
      cur_sel_q  <= '0;
      busy_q     <= 1'b0;
      wrap_q     <= 1'b0;
      rem_q      <= '0;
      bl_q       <= '0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out_d;
      cur_sel_q  <= cur_sel_d;
      busy_q     <= busy_d;
      wrap_q     <= wrap_d;
      rem_q      <= rem_d;
      bl_q       <= bl_d;
    end
  end

  assign data_out = data_out_q;
  assign cur_sel  = cur_sel_q;
  assign busy     = busy_q;
  assign wrap     = wrap_q;

endmodule

// File: doc/decoder_scan_138.md
Name: decoder_scan_138

Overview:
- Parametrised, registered successor to the 3-to-8 line decoder with 138-style triple enable.
- Two modes:
  - Direct: registered decode of a select input.
  - Scan: an internal sequencer cycles the active line through channels 0..last_idx, with programmable dwell and blanking between channels.
- Drives one-hot row/digit selects; never asserts more than one line.

Parameters:
- SEL_W, 3: select width; output width is 2**SEL_W.
- DWELL_W, 8: width of the dwell input.
- BLANK, 1: all-inactive cycles inserted between scan channels; 0 means none.
- ACTIVE_LOW, 1: 1 gives active line 0 and inactive 1; 0 inverts this.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en1_n  in  1  enable, active low.
- en2_n  in  1  enable, active low.
- en3  in  1  enable, active high.
- mode  in  1  0 = direct, 1 = scan.
- data_in  in  SEL_W  direct-mode select.
- dwell  in  DWELL_W  cycles each scan channel is active; 0 is treated as 1.
- last_idx  in  SEL_W  highest channel in scan.
- data_out  out  2**SEL_W  decoded lines, polarity per ACTIVE_LOW.
- cur_sel  out  SEL_W  currently selected index.
- busy  out  1  high in SCAN_ON or SCAN_BLANK.
- wrap  out  1  one-cycle pulse when scan returns to channel 0.

Behaviour:
- Register timing:
  - enabled = ~en1_n & ~en2_n & en3, sampled each cycle.
  - All outputs are registers updated on the same edge as the state.
- Reset (rst=1 at edge), regardless of enables:
  - state=IDLE, data_out all inactive (all 1s when ACTIVE_LOW=1), cur_sel=0, busy=0, wrap=0, dwell counter=0.
- States: IDLE, DIRECT, SCAN_ON, SCAN_BLANK.
- Disabled (any state, enabled=0):
  - Next state is IDLE; data_out goes inactive at the next edge; busy=0.
  - cur_sel is held and the dwell counter is cleared.
- Direct mode (enabled=1, mode=0):
  - Next state is DIRECT; cur_sel<=data_in; data_out<=one-hot(data_in).
  - Latency is 1 cycle.
- Entering scan (enabled=1, mode=1, state IDLE or DIRECT):
  - Next state is SCAN_ON.
  - From DIRECT: cur_sel<=0.
  - From IDLE: cur_sel is held, so the scan resumes the interrupted channel.
  - The dwell counter starts fresh.
- Dwell:
  - D = max(dwell,1), sampled when the channel starts.
  - A channel's line is active for exactly D cycles.
- SCAN_ON:
  - The line for cur_sel is active.
  - After D cycles: BLANK>0 goes to SCAN_BLANK; BLANK=0 advances directly and stays in SCAN_ON.
- SCAN_BLANK:
  - All lines inactive for BLANK cycles, then advance and go to SCAN_ON.
- Advance:
  - If cur_sel >= last_idx: cur_sel<=0 and wrap=1 on that edge, for one cycle. Otherwise cur_sel<=cur_sel+1.
  - ">=" covers last_idx lowered below cur_sel mid-scan.
  - last_idx=0 holds channel 0 and pulses wrap once per period.
- Scan period = (last_idx+1)*(D+BLANK) cycles.
- Mode change mid-scan (mode=0 at any scan point): goes to DIRECT next edge, with no blank or wrap.
- Simultaneous events:
  - rst overrides everything.
  - Disable overrides a mode change and an advance: no wrap while disabled.
- Invariant: data_out has at most one active bit in every cycle.

Test Plan:
(all with SEL_W=3, ACTIVE_LOW=1, BLANK=1)
1. Reset and disable:
   - Stimulus: rst=1 for 2 cycles, then en1_n=1, en2_n=0, en3=1, mode=0, data_in=5.
   - Required: data_out=8'hFF, busy=0, wrap=0 throughout.
2. Direct sweep:
   - Stimulus: en1_n=0, data_in=0..7, 20 cycles each.
   - Required: data_out one cycle later is FE, FD, FB, F7, EF, DF, BF, 7F; cur_sel tracks data_in.
3. Full scan:
   - Stimulus: mode=1, dwell=3, last_idx=7.
   - Required: FE for 3 cycles, FF for 1, FD for 3, FF for 1, … up to 7F; busy=1.
   - Required: on return to FE, wrap=1 for exactly 1 cycle; period = 32 cycles.
4. Short scan, zero dwell:
   - Stimulus: dwell=0, last_idx=2.
   - Required: FE, FF, FD, FF, FB, FF, FE… repeating; wrap every 6 cycles.
   - Then last_idx changed to 1 while on channel 2: required next channel is 0, with a wrap pulse.
5. Disable mid-scan:
   - Stimulus: en3=0 while channel 4 (EF) is active.
   - Required: next edge gives FF, busy=0, cur_sel=4.
   - Stimulus: re-enable. Required: EF for a full 3 cycles, then continues to DF; no wrap during the disable.
6. Reset mid-scan with enables held active and mode=1:
   - Required: FF and cur_sel=0 while rst=1.
   - Required: after release, scan restarts at channel 0 (FE); one-hot checker passes throughout all tests.
